// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer with one-second prescaler and minute counter.
// Lap capture is built only when LAP_CAPTURE_EN is defined; otherwise lap outputs read 0.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic [5:0] sec_value,
    input  logic       sec_rollover,
    output logic       cnt_enable,
    output logic       cnt_clear,
    output logic [6:0] minutes,
    output logic [1:0] state,
    output logic       done,
    output logic [6:0] lap_min,
    output logic [5:0] lap_sec,
    output logic       lap_valid
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0] M_MAX = 7'(MAX_MIN);

    logic [PW-1:0] presc;
    logic [1:0]    state_q, state_d;
    logic [6:0]    min_q;
    logic          tick, at_max;

    assign tick       = state_q == RUN && presc == P_LAST;
    assign at_max     = min_q == M_MAX && sec_value == 6'd59;
    assign cnt_enable = tick && !at_max;

    // The final tick at MAX_MIN:59 outranks a coincident start_stop so the display freezes.
    always_comb begin
        state_d = state_q;
        if (btn_clear)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = btn_start_stop ? RUN : IDLE;
        else if (state_q == RUN)
            state_d = (tick && at_max) ? DONE : btn_start_stop ? PAUSE : RUN;
        else if (state_q == PAUSE)
            state_d = btn_start_stop ? RUN : PAUSE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            presc     <= '0;
            min_q     <= '0;
            cnt_clear <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_clear <= btn_clear;
            presc     <= (btn_clear || state_q == IDLE || tick) ? '0 :
                         (state_q == RUN) ? presc + PW'(1) : presc;
            min_q     <= btn_clear ? 7'd0 :
                         (sec_rollover && state_q == RUN && min_q != M_MAX) ? min_q + 7'd1 : min_q;
        end
    end

    assign minutes = min_q;
    assign state   = state_q;
    assign done    = state_q == DONE;

`ifdef LAP_CAPTURE_EN
    logic [6:0] lap_min_q;
    logic [5:0] lap_sec_q;
    logic       lap_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || btn_clear) begin
            lap_min_q   <= '0;
            lap_sec_q   <= '0;
            lap_valid_q <= 1'b0;
        end else if (btn_lap && (state_q == RUN || state_q == PAUSE)) begin
            lap_min_q   <= min_q;
            lap_sec_q   <= sec_value;
            lap_valid_q <= 1'b1;
        end
    end

    assign lap_min   = lap_min_q;
    assign lap_sec   = lap_sec_q;
    assign lap_valid = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_min    = '0;
    assign lap_sec    = '0;
    assign lap_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized scoreboard bench; reference model tracks elapsed time in seconds.
module tb_stopwatch_ctrl;
    localparam int TD   = 4;
    localparam int MM   = 2;
    localparam int LAST = MM * 60 + 59;

    logic       clk = 1'b0;
    logic       rst, ss, clr, lap;
    logic [5:0] sec;
    logic       sec_rollover;
    logic       cnt_enable, cnt_clear, done, lap_valid;
    logic [6:0] minutes, lap_min;
    logic [1:0] state;
    logic [5:0] lap_sec;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
        .clk(clk), .rst(rst), .btn_start_stop(ss), .btn_clear(clr), .btn_lap(lap),
        .sec_value(sec), .sec_rollover(sec_rollover), .cnt_enable(cnt_enable),
        .cnt_clear(cnt_clear), .minutes(minutes), .state(state), .done(done),
        .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid)
    );

    // Paired seconds_counter environment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             sec <= '0;
        else if (cnt_clear)  sec <= '0;
        else if (cnt_enable) sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
    end
    assign sec_rollover = cnt_enable && sec == 6'd59;

    typedef struct {
        int st; int en; int mn; int dn; int cc; int lm; int ls; int lv;
    } exp_t;
    exp_t q[$];

    int n_vec = 0, n_mis = 0, done_seen = 0;
    int m_st, m_ph, m_tot, m_cc, m_lm, m_ls, m_lv;

    task automatic step(input logic r, input logic s, input logic c, input logic l);
        exp_t e;
        int tk;
        @(posedge clk);
        #1;
        rst = r; ss = s; clr = c; lap = l;
        if (r) begin
            m_st = 0; m_ph = 0; m_tot = 0; m_cc = 0; m_lm = 0; m_ls = 0; m_lv = 0;
        end
        tk   = (!r && m_st == 1 && m_ph == TD - 1) ? 1 : 0;
        e.st = m_st;
        e.en = (tk == 1 && m_tot != LAST) ? 1 : 0;
        e.mn = m_tot / 60;
        e.dn = (m_st == 3) ? 1 : 0;
        e.cc = m_cc;
        e.lm = m_lm;
        e.ls = m_ls;
        e.lv = m_lv;
        q.push_back(e);
        if (!r) begin
            m_cc = c ? 1 : 0;
            if (c) begin
                m_st = 0; m_tot = 0; m_ph = 0; m_lm = 0; m_ls = 0; m_lv = 0;
            end else begin
`ifdef LAP_CAPTURE_EN
                if (l && (m_st == 1 || m_st == 2)) begin
                    m_lm = m_tot / 60; m_ls = m_tot % 60; m_lv = 1;
                end
`endif
                case (m_st)
                    0: if (s) begin m_st = 1; m_ph = 0; end
                    1: if (tk == 1 && m_tot == LAST) m_st = 3;
                       else begin
                           if (tk == 1) m_tot = m_tot + 1;
                           m_ph = (tk == 1) ? 0 : m_ph + 1;
                           if (s) m_st = 2;
                       end
                    2: if (s) m_st = 1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cmp(input string n, input int got, input int want);
        if (got != want) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0d want %0d", n, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            cmp("state", int'(state), e.st);
            cmp("cnt_enable", int'(cnt_enable), e.en);
            cmp("minutes", int'(minutes), e.mn);
            cmp("done", int'(done), e.dn);
            cmp("cnt_clear", int'(cnt_clear), e.cc);
            cmp("lap_min", int'(lap_min), e.lm);
            cmp("lap_sec", int'(lap_sec), e.ls);
            cmp("lap_valid", int'(lap_valid), e.lv);
            if (done) done_seen++;
        end
    end

    initial begin
        rst = 1'b1; ss = 1'b0; clr = 1'b0; lap = 1'b0;
        repeat (3) step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (24) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (40) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (800) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (30) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (310) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        for (int g = 0; g < 30; g++) begin
            int len, sr, cr, sel;
            len = $urandom_range(100, 1500);
            sel = $urandom_range(0, 2);
            sr  = (sel == 0) ? 4 : (sel == 1) ? 60 : 2000;
            sel = $urandom_range(0, 2);
            cr  = (sel == 0) ? 0 : (sel == 1) ? 300 : 3000;
            for (int i = 0; i < len; i++)
                step(0, $urandom_range(0, sr - 1) == 0,
                     cr != 0 && $urandom_range(0, cr - 1) == 0,
                     $urandom_range(0, 19) == 0);
            if (g == 15) repeat (3) step(1, $urandom_range(0, 1) == 1, 0, 0);
        end
        step(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        n_vec++;
        if (done_seen == 0) begin
            n_mis++;
            $display("FAIL done_reached: got %0d done cycles want >0", done_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
